// File: rtl/alu_result_stage_pkg.sv
// -----------------------------------------------------------------------------
// alu_result_stage_pkg
//   Shared definitions for the ALU result stage:
//     - datapath widths (must match the 16-bit ALU)
//     - ALU op code constants and the highest legal op code
//     - branch condition selector codes
//     - the buffered entry struct carried through the skid buffer
//     - the skid buffer occupancy state (also exported for debug)
// -----------------------------------------------------------------------------
package alu_result_stage_pkg;

    localparam int ALU_DATA_W = 16;
    localparam int ALU_DEST_W = 4;

    // ALU op codes; anything above OP_MAX is illegal.
    localparam logic [3:0] OP_AND = 4'd0;
    localparam logic [3:0] OP_OR  = 4'd1;
    localparam logic [3:0] OP_ADD = 4'd2;
    localparam logic [3:0] OP_SUB = 4'd3;
    localparam logic [3:0] OP_XOR = 4'd4;
    localparam logic [3:0] OP_SHL = 4'd5;
    localparam logic [3:0] OP_SHR = 4'd6;
    localparam logic [3:0] OP_INV = 4'd7;
    localparam logic [3:0] OP_MAX = OP_INV;

    // Branch condition selectors.
    localparam logic [2:0] BR_AL = 3'd0;
    localparam logic [2:0] BR_EQ = 3'd1;
    localparam logic [2:0] BR_NE = 3'd2;
    localparam logic [2:0] BR_LT = 3'd3;
    localparam logic [2:0] BR_GE = 3'd4;
    localparam logic [2:0] BR_GT = 3'd5;
    localparam logic [2:0] BR_LE = 3'd6;
    localparam logic [2:0] BR_VS = 3'd7;

    // One buffered writeback entry.
    typedef struct packed {
        logic [ALU_DATA_W-1:0] result;
        logic [ALU_DEST_W-1:0] dest;
        logic                  err;
    } entry_t;

    // Skid buffer occupancy: empty, main only, main + skid.
    typedef enum logic [1:0] {
        BUF_EMPTY = 2'd0,
        BUF_ONE   = 2'd1,
        BUF_FULL  = 2'd2
    } buf_state_t;

endpackage

// File: rtl/alu_result_stage_if.sv
// -----------------------------------------------------------------------------
// alu_result_stage_if
//   Bundles the ALU-side input handshake, the writeback-side output handshake,
//   the flush, the condition-code outputs and the branch evaluator port.
//
//   Handshake semantics (both sides): a transfer happens on a rising clk edge
//   where valid & ready are both high. A producer holding valid high must keep
//   its payload stable until the transfer; ready may change freely.
//
//   Modports:
//     master : the ALU / writeback / control side that drives the stage
//     slave  : the alu_result_stage itself
// -----------------------------------------------------------------------------
interface alu_result_stage_if;
    import alu_result_stage_pkg::*;

    // ALU side
    logic                  in_valid;
    logic                  in_ready;
    logic [ALU_DATA_W-1:0] in_result;
    logic                  in_zero;
    logic                  in_neg;
    logic                  in_ovfl;
    logic [3:0]            in_op;
    logic [ALU_DEST_W-1:0] in_dest;
    logic                  in_setcc;
    logic                  flush;

    // Writeback side
    logic                  out_valid;
    logic                  out_ready;
    logic [ALU_DATA_W-1:0] out_result;
    logic [ALU_DEST_W-1:0] out_dest;
    logic                  out_err;

    // Condition codes and branch evaluation
    logic                  cc_z;
    logic                  cc_n;
    logic                  cc_v;
    logic [2:0]            br_cond;
    logic                  br_taken;

    modport master (
        output in_valid, in_result, in_zero, in_neg, in_ovfl, in_op, in_dest,
               in_setcc, flush, out_ready, br_cond,
        input  in_ready, out_valid, out_result, out_dest, out_err,
               cc_z, cc_n, cc_v, br_taken
    );

    modport slave (
        input  in_valid, in_result, in_zero, in_neg, in_ovfl, in_op, in_dest,
               in_setcc, flush, out_ready, br_cond,
        output in_ready, out_valid, out_result, out_dest, out_err,
               cc_z, cc_n, cc_v, br_taken
    );

endinterface

// File: rtl/alu_result_stage_skid_buf2.sv
// -----------------------------------------------------------------------------
// alu_result_stage_skid_buf2
//   Two-entry valid/ready skid buffer carrying entry_t. The main register
//   drives the output; the skid register catches an accept that arrives while
//   main is held by backpressure. o_ready is a pure register decode (not full),
//   so it has no combinational path from i_ready.
//
// Ports:
//   clk, rst_n  clock, asynchronous active-low reset
//   i_clr       discard both entries; blocks any same-cycle accept
//   i_valid     upstream entry valid
//   o_ready     buffer can accept (skid register empty)
//   i_data      upstream entry
//   o_valid     main register holds an entry
//   i_ready     downstream consumes the main entry
//   o_data      main register contents
//   o_state     occupancy state for debug
// -----------------------------------------------------------------------------
module alu_result_stage_skid_buf2
    import alu_result_stage_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       i_clr,
    input  logic       i_valid,
    output logic       o_ready,
    input  entry_t     i_data,
    output logic       o_valid,
    input  logic       i_ready,
    output entry_t     o_data,
    output buf_state_t o_state
);

    buf_state_t r_state;
    buf_state_t w_state_nxt;
    entry_t     r_main;
    entry_t     r_skid;

    logic w_accept;
    logic w_drain;
    logic w_load_main_in;
    logic w_load_main_skid;
    logic w_load_skid;

    assign o_ready  = (r_state != BUF_FULL);
    assign o_valid  = (r_state != BUF_EMPTY);
    assign o_data   = r_main;
    assign o_state  = r_state;

    assign w_accept = i_valid & o_ready & ~i_clr;
    assign w_drain  = o_valid & i_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= BUF_EMPTY;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt      = r_state;
        w_load_main_in   = 1'b0;
        w_load_main_skid = 1'b0;
        w_load_skid      = 1'b0;
        if (i_clr) begin
            w_state_nxt = BUF_EMPTY;
        end else begin
            case (r_state)
                BUF_EMPTY: begin
                    if (w_accept) begin
                        w_state_nxt    = BUF_ONE;
                        w_load_main_in = 1'b1;
                    end
                end
                BUF_ONE: begin
                    if (w_drain && w_accept) begin
                        // Pass-through: main is refilled directly, skid stays empty.
                        w_load_main_in = 1'b1;
                    end else if (w_drain) begin
                        w_state_nxt = BUF_EMPTY;
                    end else if (w_accept) begin
                        w_state_nxt = BUF_FULL;
                        w_load_skid = 1'b1;
                    end
                end
                BUF_FULL: begin
                    // o_ready is low here, so no accept can coincide.
                    if (w_drain) begin
                        w_state_nxt      = BUF_ONE;
                        w_load_main_skid = 1'b1;
                    end
                end
                default: begin
                    w_state_nxt = BUF_EMPTY;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_main <= '0;
            r_skid <= '0;
        end else begin
            if (w_load_main_in) begin
                r_main <= i_data;
            end else if (w_load_main_skid) begin
                r_main <= r_skid;
            end
            if (w_load_skid) begin
                r_skid <= i_data;
            end
        end
    end

endmodule

// File: rtl/alu_result_stage.sv
// -----------------------------------------------------------------------------
// alu_result_stage
//   Execute-to-writeback stage behind the 16-bit ALU. Each accepted ALU result
//   is queued in a 2-entry skid buffer towards writeback; the condition-code
//   register (Z, N, V) is updated at acceptance time and drives a
//   combinational branch-condition evaluator.
//
// Ports:
//   clk         rising-edge clock
//   rst_n       asynchronous active-low reset
//   bus         alu_result_stage_if.slave:
//                 in_*      ALU result, flags, op, dest, setcc with valid/ready
//                 flush     drop all buffered entries and the same-cycle input
//                 out_*     writeback entry with valid/ready, err = illegal op
//                 cc_z/n/v  condition-code register
//                 br_cond   branch selector, br_taken its evaluation
//   o_dbg_state skid buffer occupancy
// -----------------------------------------------------------------------------
module alu_result_stage
    import alu_result_stage_pkg::*;
#(
    parameter int DATA_W = ALU_DATA_W,
    parameter int DEST_W = ALU_DEST_W
) (
    input  logic                 clk,
    input  logic                 rst_n,
    alu_result_stage_if.slave    bus,
    output buf_state_t           o_dbg_state
);

    entry_t w_in_entry;
    entry_t w_out_entry;
    logic   w_in_ready;
    logic   w_out_valid;
    logic   w_accept;
    logic   w_op_legal;
    logic   w_lt;

    logic   r_cc_z;
    logic   r_cc_n;
    logic   r_cc_v;

    assign w_op_legal = (bus.in_op <= OP_MAX);
    assign w_in_entry = '{result: bus.in_result[DATA_W-1:0],
                          dest:   bus.in_dest[DEST_W-1:0],
                          err:    ~w_op_legal};

    alu_result_stage_skid_buf2 u_skid (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_clr   (bus.flush),
        .i_valid (bus.in_valid),
        .o_ready (w_in_ready),
        .i_data  (w_in_entry),
        .o_valid (w_out_valid),
        .i_ready (bus.out_ready),
        .o_data  (w_out_entry),
        .o_state (o_dbg_state)
    );

    assign bus.in_ready   = w_in_ready;
    assign bus.out_valid  = w_out_valid;
    assign bus.out_result = w_out_entry.result;
    assign bus.out_dest   = w_out_entry.dest;
    assign bus.out_err    = w_out_entry.err;

    // Same acceptance rule the buffer uses; flush suppresses the cc update too.
    assign w_accept = bus.in_valid & w_in_ready & ~bus.flush;

    // Codes are set when the entry is accepted, not when it is written back.
    // V is only meaningful for add/sub; the ALU leaves ovfl undefined otherwise.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cc_z <= 1'b0;
            r_cc_n <= 1'b0;
            r_cc_v <= 1'b0;
        end else if (w_accept && bus.in_setcc && w_op_legal) begin
            r_cc_z <= bus.in_zero;
            r_cc_n <= bus.in_neg;
            r_cc_v <= ((bus.in_op == OP_ADD) || (bus.in_op == OP_SUB)) ? bus.in_ovfl : 1'b0;
        end
    end

    assign bus.cc_z = r_cc_z;
    assign bus.cc_n = r_cc_n;
    assign bus.cc_v = r_cc_v;

    // Signed less-than from the codes.
    assign w_lt = r_cc_n ^ r_cc_v;

    always_comb begin
        bus.br_taken = 1'b0;
        case (bus.br_cond)
            BR_AL:   bus.br_taken = 1'b1;
            BR_EQ:   bus.br_taken = r_cc_z;
            BR_NE:   bus.br_taken = ~r_cc_z;
            BR_LT:   bus.br_taken = w_lt;
            BR_GE:   bus.br_taken = ~w_lt;
            BR_GT:   bus.br_taken = ~r_cc_z & ~w_lt;
            BR_LE:   bus.br_taken = r_cc_z | w_lt;
            BR_VS:   bus.br_taken = r_cc_v;
            default: bus.br_taken = 1'b0;
        endcase
    end

endmodule

// File: tb/tb_alu_result_stage.sv
module tb_alu_result_stage;
    import alu_result_stage_pkg::*;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    alu_result_stage_if bus_if ();
    buf_state_t dbg_state;

    alu_result_stage dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .bus         (bus_if),
        .o_dbg_state (dbg_state)
    );

    // ---------------- counters / check ----------------
    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // FIFO of {result, dest, err}, at most two deep; head is what writeback sees.
    logic [20:0] exp_q[$];
    logic m_z = 1'b0, m_n = 1'b0, m_v = 1'b0;

    function automatic logic model_br(input logic [2:0] c, input logic z, input logic n, input logic v);
        logic less;
        less = (n != v);
        case (c)
            3'd0: return 1'b1;
            3'd1: return z;
            3'd2: return !z;
            3'd3: return less;
            3'd4: return !less;
            3'd5: return !z && !less;
            3'd6: return z || less;
            default: return v;
        endcase
    endfunction

    always @(negedge rst_n) begin
        exp_q.delete();
        m_z = 1'b0; m_n = 1'b0; m_v = 1'b0;
    end

    always @(posedge clk) begin
        bit acc, drn;
        if (!rst_n) begin
            exp_q.delete();
            m_z = 1'b0; m_n = 1'b0; m_v = 1'b0;
        end else begin
            acc = bus_if.in_valid && (exp_q.size() < 2) && !bus_if.flush;
            drn = (exp_q.size() > 0) && bus_if.out_ready;
            if (acc && bus_if.in_setcc && (bus_if.in_op <= 4'd7)) begin
                m_z = bus_if.in_zero;
                m_n = bus_if.in_neg;
                m_v = (bus_if.in_op == 4'd2 || bus_if.in_op == 4'd3) ? bus_if.in_ovfl : 1'b0;
            end
            if (bus_if.flush) begin
                exp_q.delete();
            end else begin
                if (drn) void'(exp_q.pop_front());
                if (acc) exp_q.push_back({bus_if.in_result, bus_if.in_dest, (bus_if.in_op > 4'd7)});
            end
        end
    end

    // ---------------- compare process ----------------
    always @(negedge clk) begin
        chk("in_ready", 32'(bus_if.in_ready), 32'(exp_q.size() < 2));
        chk("out_valid", 32'(bus_if.out_valid), 32'(exp_q.size() > 0));
        if (exp_q.size() > 0) begin
            chk("out_result", 32'(bus_if.out_result), 32'(exp_q[0][20:5]));
            chk("out_dest", 32'(bus_if.out_dest), 32'(exp_q[0][4:1]));
            chk("out_err", 32'(bus_if.out_err), 32'(exp_q[0][0]));
        end
        chk("cc", 32'({bus_if.cc_z, bus_if.cc_n, bus_if.cc_v}), 32'({m_z, m_n, m_v}));
        chk("br_taken", 32'(bus_if.br_taken), 32'(model_br(bus_if.br_cond, m_z, m_n, m_v)));
    end

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_in(input logic [15:0] res, input logic [3:0] dest, input logic [3:0] op,
                            input logic z, input logic n, input logic v, input logic setcc);
        bus_if.in_valid  = 1'b1;
        bus_if.in_result = res;
        bus_if.in_dest   = dest;
        bus_if.in_op     = op;
        bus_if.in_zero   = z;
        bus_if.in_neg    = n;
        bus_if.in_ovfl   = v;
        bus_if.in_setcc  = setcc;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        bus_if.in_valid  = 1'b0;
        bus_if.in_result = '0;
        bus_if.in_dest   = '0;
        bus_if.in_op     = '0;
        bus_if.in_zero   = 1'b0;
        bus_if.in_neg    = 1'b0;
        bus_if.in_ovfl   = 1'b0;
        bus_if.in_setcc  = 1'b0;
        bus_if.flush     = 1'b0;
        bus_if.out_ready = 1'b0;
        bus_if.br_cond   = 3'd0;
        #2 rst_n = 1'b0;

        // Reset state
        @(negedge clk);
        chk("rst out_valid", 32'(bus_if.out_valid), 32'd0);
        chk("rst in_ready", 32'(bus_if.in_ready), 32'd1);
        chk("rst out_result", 32'(bus_if.out_result), 32'd0);
        chk("rst out_dest", 32'(bus_if.out_dest), 32'd0);
        chk("rst out_err", 32'(bus_if.out_err), 32'd0);
        chk("rst cc", 32'({bus_if.cc_z, bus_if.cc_n, bus_if.cc_v}), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        step();

        // Single accept, 1-cycle latency
        bus_if.out_ready = 1'b1;
        drive_in(16'h1234, 4'd3, 4'd2, 1'b0, 1'b0, 1'b0, 1'b0);
        step();
        bus_if.in_valid = 1'b0;
        @(negedge clk);
        chk("t1 out_valid", 32'(bus_if.out_valid), 32'd1);
        chk("t1 out_result", 32'(bus_if.out_result), 32'h1234);
        chk("t1 out_dest", 32'(bus_if.out_dest), 32'd3);
        chk("t1 out_err", 32'(bus_if.out_err), 32'd0);
        step();
        @(negedge clk);
        chk("t1 drained", 32'(bus_if.out_valid), 32'd0);

        // Backpressure fills both entries, then drains in order
        step();
        bus_if.out_ready = 1'b0;
        drive_in(16'h0001, 4'd1, 4'd1, 1'b0, 1'b0, 1'b0, 1'b0);
        step();
        drive_in(16'h0002, 4'd2, 4'd1, 1'b0, 1'b0, 1'b0, 1'b0);
        step();
        bus_if.in_valid = 1'b0;
        @(negedge clk);
        chk("t2 full in_ready", 32'(bus_if.in_ready), 32'd0);
        chk("t2 head", 32'(bus_if.out_result), 32'h0001);
        bus_if.out_ready = 1'b1;
        step();
        @(negedge clk);
        chk("t2 second", 32'(bus_if.out_result), 32'h0002);
        chk("t2 in_ready", 32'(bus_if.in_ready), 32'd1);
        step();
        @(negedge clk);
        chk("t2 empty", 32'(bus_if.out_valid), 32'd0);

        // Add with overflow sets N and V
        step();
        drive_in(16'h8000, 4'd5, 4'd2, 1'b0, 1'b1, 1'b1, 1'b1);
        step();
        bus_if.in_valid = 1'b0;
        bus_if.br_cond  = 3'd3;
        @(negedge clk);
        chk("t3 cc_n", 32'(bus_if.cc_n), 32'd1);
        chk("t3 cc_v", 32'(bus_if.cc_v), 32'd1);
        chk("t3 cc_z", 32'(bus_if.cc_z), 32'd0);
        chk("t3 LT", 32'(bus_if.br_taken), 32'd0);
        step();
        bus_if.br_cond = 3'd7;
        @(negedge clk);
        chk("t3 VS", 32'(bus_if.br_taken), 32'd1);

        // Logic op masks V; illegal op flags err and leaves codes alone
        step();
        drive_in(16'h0000, 4'd6, 4'd0, 1'b1, 1'b0, 1'b1, 1'b1);
        step();
        bus_if.in_valid = 1'b0;
        bus_if.br_cond  = 3'd1;
        @(negedge clk);
        chk("t4 cc_v", 32'(bus_if.cc_v), 32'd0);
        chk("t4 cc_z", 32'(bus_if.cc_z), 32'd1);
        chk("t4 EQ", 32'(bus_if.br_taken), 32'd1);
        step();
        drive_in(16'h0009, 4'd7, 4'd9, 1'b0, 1'b1, 1'b1, 1'b1);
        step();
        bus_if.in_valid = 1'b0;
        @(negedge clk);
        chk("t4 out_err", 32'(bus_if.out_err), 32'd1);
        chk("t4 cc kept", 32'({bus_if.cc_z, bus_if.cc_n, bus_if.cc_v}), 32'b100);

        // Flush with full buffer and a concurrent input
        step();
        bus_if.out_ready = 1'b0;
        drive_in(16'h00A1, 4'd1, 4'd1, 1'b0, 1'b0, 1'b0, 1'b1);
        step();
        drive_in(16'h00A2, 4'd2, 4'd1, 1'b0, 1'b0, 1'b0, 1'b1);
        step();
        drive_in(16'hBEEF, 4'd8, 4'd2, 1'b1, 1'b0, 1'b0, 1'b1);
        bus_if.flush = 1'b1;
        step();
        bus_if.flush    = 1'b0;
        bus_if.in_valid = 1'b0;
        @(negedge clk);
        chk("t5 out_valid", 32'(bus_if.out_valid), 32'd0);
        chk("t5 in_ready", 32'(bus_if.in_ready), 32'd1);
        chk("t5 cc_z", 32'(bus_if.cc_z), 32'd0);
        bus_if.out_ready = 1'b1;
        repeat (3) step();
        @(negedge clk);
        chk("t5 no BEEF", 32'(bus_if.out_valid), 32'd0);

        // Async reset mid-stall
        step();
        bus_if.out_ready = 1'b0;
        drive_in(16'h0011, 4'd1, 4'd1, 1'b0, 1'b1, 1'b0, 1'b1);
        step();
        drive_in(16'h0022, 4'd2, 4'd1, 1'b0, 1'b1, 1'b0, 1'b1);
        step();
        bus_if.in_valid = 1'b0;
        bus_if.in_setcc = 1'b0;
        #3 rst_n = 1'b0;
        #1;
        chk("t6 out_valid", 32'(bus_if.out_valid), 32'd0);
        chk("t6 cc", 32'({bus_if.cc_z, bus_if.cc_n, bus_if.cc_v}), 32'd0);
        chk("t6 in_ready", 32'(bus_if.in_ready), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        step();

        // Randomized traffic against the model
        for (int i = 0; i < 800; i++) begin
            bus_if.in_valid  = 1'($urandom_range(0, 1));
            bus_if.in_result = 16'($urandom_range(0, 65535));
            bus_if.in_dest   = 4'($urandom_range(0, 15));
            bus_if.in_op     = 4'($urandom_range(0, 15));
            bus_if.in_zero   = 1'($urandom_range(0, 1));
            bus_if.in_neg    = 1'($urandom_range(0, 1));
            bus_if.in_ovfl   = 1'($urandom_range(0, 1));
            bus_if.in_setcc  = 1'($urandom_range(0, 1));
            bus_if.flush     = ($urandom_range(0, 15) == 0);
            bus_if.out_ready = ($urandom_range(0, 3) != 0);
            bus_if.br_cond   = 3'($urandom_range(0, 7));
            step();
        end
        bus_if.in_valid  = 1'b0;
        bus_if.flush     = 1'b0;
        bus_if.out_ready = 1'b1;
        repeat (4) step();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/alu_result_stage.md
Name: alu_result_stage

Overview:
- Execute-to-writeback pipeline stage directly downstream of the datapath 16-bit ALU; captures each ALU result and its zero/negative/overflow flags.
- Buffers results in a 2-entry skid buffer so writeback backpressure never corrupts an in-flight result.
- Holds the architectural condition-code register (Z, N, V) and evaluates branch conditions from it for the control unit.

Parameters:
- DATA_W, 16, result width; must match ALU width.
- DEST_W, 4, destination register index width.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  ALU output is valid this cycle.
- in_ready  out  1  stage can accept an entry.
- in_result  in  DATA_W  ALU result R.
- in_zero  in  1  ALU isZero.
- in_neg  in  1  ALU isNegative.
- in_ovfl  in  1  ALU ovfl.
- in_op  in  4  ALU op code that produced the entry.
- in_dest  in  DEST_W  destination register index.
- in_setcc  in  1  entry updates the condition codes.
- flush  in  1  discard all buffered entries (branch or exception).
- out_valid  out  1  writeback entry valid.
- out_ready  in  1  writeback consumes the entry.
- out_result  out  DATA_W  buffered result.
- out_dest  out  DEST_W  buffered destination.
- out_err  out  1  entry came from an illegal op (op > 7).
- cc_z, cc_n, cc_v  out  1 each  condition-code register.
- br_cond  in  3  branch condition selector.
- br_taken  out  1  combinational condition result.

Behaviour:
- Reset (async, rst_n=0): main and skid entries invalid; out_valid=0, out_result=0, out_dest=0, out_err=0, in_ready=1, cc_z=cc_n=cc_v=0. Deassertion takes effect at the next clk edge.
- Accept: an entry is accepted when in_valid & in_ready & ~flush.
- Latency: an accepted entry appears at out_* on the next cycle when main is empty (1-cycle latency).
- Skid buffer:
  - Main register drives out_*. Skid register catches an accept when main is occupied and not draining (out_valid & ~out_ready).
  - in_ready is registered and equals ~skid_valid.
  - A drain is out_valid & out_ready. On drain, skid moves to main if occupied; otherwise main takes the new accept or becomes empty.
  - A simultaneous drain and accept with skid empty reloads main directly. Throughput is 1 entry/cycle.
- Full: with both entries occupied, in_ready=0. in_valid is ignored until a drain.
- out_* holds stable while out_valid & ~out_ready.
- out_err=1 when in_op > 7. The entry still flows to writeback, but it never updates the condition codes.
- Condition codes: updated on the accept edge when in_setcc=1 and in_op <= 7, and are visible the cycle after.
  - cc_z <= in_zero; cc_n <= in_neg.
  - cc_v <= in_ovfl only for op 2 (add) and op 3 (sub); otherwise cc_v <= 0. The ALU does not drive ovfl for logic ops.
  - Update happens at acceptance, not at writeback, so a stalled entry has already set the codes.
- Flush (priority over everything):
  - Next cycle: main and skid invalid, out_valid=0, in_ready=1.
  - The same-cycle input is not accepted and makes no cc update.
  - cc_* retain their prior value.
- br_taken (combinational from cc_* only):
  - 0 always; 1 EQ (Z); 2 NE (~Z); 3 LT (N^V); 4 GE ~(N^V).
  - 5 GT (~Z & ~(N^V)); 6 LE (Z | (N^V)); 7 VS (V).
- Reset mid-operation clears all entries immediately. In-flight data is lost by design.

Decomposition:
- Shared package: ALU op code constants (AND=0 … INV=7, OP_MAX=7); branch condition codes BR_AL … BR_VS; DATA_W; a struct for one buffered entry {result, dest, err}.
- One sub-module: skid_buf2, a generic 2-entry valid/ready skid buffer carrying the entry struct. The condition-code register and branch evaluator remain in the top.

Test Plan:
- Reset, then one accept: in_result=16'h1234, dest=3, op=2, out_ready=1 -> next cycle out_valid=1, out_result=16'h1234, out_dest=3, out_err=0; following cycle out_valid=0.
- Backpressure: out_ready=0; accept 16'h0001, then 16'h0002 -> in_ready=0 after the second accept. Raise out_ready -> outputs 0001 then 0002 in order, in_ready=1 again, no loss or duplication.
- CC from add overflow: op=2, R=16'h8000, neg=1, ovfl=1, setcc=1 -> cc_n=1, cc_v=1, cc_z=0; br_cond=3 (LT) -> br_taken=0; br_cond=7 -> 1.
- Logic op masking: op=0, ovfl=1 (garbage), zero=1, setcc=1 -> cc_v=0, cc_z=1; br_cond=1 -> br_taken=1. Illegal op=9 with setcc=1 -> out_err=1, cc unchanged.
- Flush with full buffer plus concurrent in_valid (16'hBEEF, setcc=1, zero=1) -> next cycle out_valid=0, in_ready=1, BEEF never emitted, cc_z unchanged.
- Async reset asserted mid-stall with both entries full -> out_valid=0 and cc_*=0 immediately, without waiting for a clk edge.
